// File: rtl/counter_event_pkg.sv
// Shared types for the counter event timer: FSM state encoding.
// The command struct is width-dependent, so it is declared inside the top module.
package counter_event_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam int unsigned DEF_COUNTER_BIT_WIDTH = 8;
  localparam int unsigned DEF_MATCH_CNT_WIDTH   = 16;

endpackage

// File: rtl/counter_event_timer_cmp.sv
// Equality compare against the armed target, registered event pulse,
// and target + period reload adder (modulo 2^W).
module counter_event_cmp
  import counter_event_pkg::*;
#(
  parameter int unsigned W = DEF_COUNTER_BIT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] count_in,
  input  logic [W-1:0] target,
  input  logic [W-1:0] period,
  output logic         match,
  output logic         hit,
  output logic [W-1:0] next_target
);

  assign match       = enable && (count_in == target);
  assign next_target = target + period;

  always_ff @(posedge clk) begin
    if (!rst) hit <= 1'b0;
    else      hit <= match;
  end

endmodule

// File: rtl/counter_event_timer.sv
// Fires a one-cycle event_pulse when the upstream counter reaches a target.
// Optional COUNTER_EVENT_OVERRUN_EN: detect upstream discontinuities, set missed.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_ARMED | comparing count_in against target every cycle
module counter_event_timer
  import counter_event_pkg::*;
#(
  parameter int unsigned COUNTER_BIT_WIDTH = DEF_COUNTER_BIT_WIDTH,
  parameter int unsigned MATCH_CNT_WIDTH   = DEF_MATCH_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COUNTER_BIT_WIDTH-1:0] count_in,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [COUNTER_BIT_WIDTH-1:0] cmd_target,
  input  logic [COUNTER_BIT_WIDTH-1:0] cmd_period,
  input  logic                         cmd_periodic,
  input  logic                         cancel,
  output logic                         event_pulse,
  output logic                         armed,
  output logic [MATCH_CNT_WIDTH-1:0]   match_count,
  output logic                         missed
);

  localparam int unsigned W = COUNTER_BIT_WIDTH;
  localparam logic [MATCH_CNT_WIDTH-1:0] MC_ONE = {{(MATCH_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [W-1:0] target;
    logic [W-1:0] period;
    logic         periodic;
  } cmd_t;

  state_t       state;
  cmd_t         cmd_q;
  logic         match;
  logic [W-1:0] next_target;
  logic         reload;

  counter_event_cmp #(.W(W)) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .enable      (state == ST_ARMED),
    .count_in    (count_in),
    .target      (cmd_q.target),
    .period      (cmd_q.period),
    .match       (match),
    .hit         (event_pulse),
    .next_target (next_target)
  );

  // cancel coinciding with a match still lets the event fire, but stops reload
  assign reload = cmd_q.periodic && (cmd_q.period != '0) && !cancel;

`ifdef COUNTER_EVENT_OVERRUN_EN
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
  logic [W-1:0] prev_count;
  logic         disc;
  logic         missed_q;

  always_ff @(posedge clk) begin
    if (!rst) prev_count <= '0;
    else      prev_count <= count_in;
  end

  assign disc   = (count_in != (prev_count + CNT_ONE));
  assign missed = missed_q;
`else
  assign missed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      armed       <= 1'b0;
      cmd_ready   <= 1'b1;
      match_count <= '0;
`ifdef COUNTER_EVENT_OVERRUN_EN
      missed_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_q.target   <= cmd_target;
            cmd_q.period   <= cmd_period;
            cmd_q.periodic <= cmd_periodic;
            match_count    <= '0;
`ifdef COUNTER_EVENT_OVERRUN_EN
            missed_q       <= 1'b0;
`endif
            state          <= ST_ARMED;
            armed          <= 1'b1;
            cmd_ready      <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (match) begin
            if (match_count != '1) match_count <= match_count + MC_ONE;
            if (reload) begin
              cmd_q.target <= next_target;
            end else begin
              state     <= ST_IDLE;
              armed     <= 1'b0;
              cmd_ready <= 1'b1;
            end
`ifdef COUNTER_EVENT_OVERRUN_EN
          end else if (disc) begin
            missed_q  <= 1'b1;
            state     <= ST_IDLE;
            armed     <= 1'b0;
            cmd_ready <= 1'b1;
`endif
          end else if (cancel) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          armed     <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/counter_event_timer.md
Name: counter_event_timer

Overview:
- Sits directly downstream of `counter`. Consumes its free-running `data_out` value as `count_in` and turns it into timed events.
- Software-side logic arms it through a valid/ready command: a target count, plus an optional reload period for periodic mode.
- The block emits a one-cycle `event_pulse` when the count matches the target, and keeps an event tally.
- Feeds interrupt/sequencing logic that needs "fire at count N" or "fire every P counts".

Parameters:
- COUNTER_BIT_WIDTH, 8, width of `count_in` / target / period; must equal the upstream counter width.
- MATCH_CNT_WIDTH, 16, width of the saturating event tally `match_count`.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- count_in  input  COUNTER_BIT_WIDTH  live value from upstream counter; increments by 1 per cycle and wraps.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_target  input  COUNTER_BIT_WIDTH  first match value.
- cmd_period  input  COUNTER_BIT_WIDTH  reload increment for periodic mode.
- cmd_periodic  input  1  1 = re-arm after each match, 0 = one-shot.
- cancel  input  1  abort an armed timer.
- event_pulse  output  1  registered one-cycle pulse per match.
- armed  output  1  high while in ARMED.
- match_count  output  MATCH_CNT_WIDTH  number of events since last accepted command; saturating.
- missed  output  1  sticky overrun flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; event_pulse=0, armed=0, match_count=0, missed=0.
  - target and period registers cleared; cmd_ready=1 from the first cycle after reset release.
  - Reset mid-ARMED drops the timer silently; no event.
- States: IDLE, ARMED.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch target, period, periodic; clear match_count and missed; go to ARMED.
  - cancel is ignored in IDLE.
- ARMED:
  - cmd_ready=0; commands are stalled, never dropped.
  - Comparison starts the cycle after acceptance. If cmd_target==count_in on the accept cycle, the match is not taken; it fires after the counter wraps.
- Match: count_in==target sampled at edge N gives event_pulse=1 for exactly the cycle after edge N (latency 1).
  - match_count increments at edge N and saturates at all-ones.
- After a match:
  - One-shot: go to IDLE at edge N.
  - Periodic with period!=0: target <= target+period mod 2^COUNTER_BIT_WIDTH; stay ARMED. Period 1 gives a pulse every cycle.
  - Periodic with period==0: behaves as one-shot.
- cancel in ARMED without a match: go to IDLE next edge; no pulse; match_count unchanged.
- cancel and match in the same cycle: the event fires and counts; the block then goes to IDLE, even if periodic.
- Width rules: all target arithmetic is modulo 2^COUNTER_BIT_WIDTH. Unsigned equality compare only, no magnitude compare.

Optional Feature:
- Macro: COUNTER_EVENT_OVERRUN_EN.
- With the macro: the block registers the previous count_in.
  - In ARMED, if count_in != prev+1 (mod 2^W), it treats the upstream counter as reset or skipped.
  - missed is set (sticky until next command accept), state goes to IDLE, and no pulse is generated.
  - Match takes priority if the match and the discontinuity occur in the same cycle.
- Without the macro: missed is tied 0, no previous-count register exists, and discontinuities are not detected.

Decomposition:
- Package `counter_event_pkg`: state enum typedef (IDLE, ARMED) and the command struct (target, period, periodic), parameterised by width via typedef in the module.
- One natural sub-module, `counter_event_cmp`: registered equality compare plus target reload adder, producing the hit strobe and next target.

Test Plan (W=8):
- Reset, then command target=20, one-shot, while counter is at 5.
  - event_pulse high exactly one cycle, in the cycle after count_in==20.
  - match_count=1; cmd_ready returns 1 in that cycle.
- Periodic: target=250, period=10.
  - Pulses after counts 250, 4, 14, 24 (wrap).
  - match_count=4 after the fourth pulse; armed stays 1.
- cancel asserted while armed with target=100, at count 60: armed drops next cycle, no pulse at 100, match_count=0.
- cancel asserted in the same cycle count_in==target=30 with periodic=1: one pulse, then IDLE, match_count=1.
- Command accepted while count_in==target=40: no pulse at that cycle; first pulse after count 40 on the next wrap (256 cycles later).
- With COUNTER_EVENT_OVERRUN_EN defined: armed target=200; assert upstream counter reset at count 120.
  - missed=1, armed=0, no pulse.
  - A new command clears missed.
